// File: rtl/absmem_rd.sv
// Abstract read memory shared by an implementation port (vlg) and an ILA port:
// the first read of an address returns a free value, later reads replay it.
module absmem_rd #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic          compare,
  input  logic [AW-1:0] vlg_raddr,
  input  logic          vlg_ren,
  input  logic [DW-1:0] vlg_r_rand_input,
  output logic [DW-1:0] vlg_rdata,
  input  logic [AW-1:0] ila_raddr,
  input  logic          ila_ren,
  input  logic [DW-1:0] ila_r_rand_input,
  output logic [DW-1:0] ila_rdata,
  output logic          equal,
  output logic          overflow
);

  localparam logic [DEPTH-1:0] ONE_C     = DEPTH'(1);
  localparam logic [3:0]       CNT_MAX_C = 4'd15;

  logic                 start_r;
  logic [DEPTH-1:0]     v_r;
  logic [AW-1:0]        addr_r    [DEPTH];
  logic [DW-1:0]        data_r    [DEPTH];
  logic [AW-1:0]        vlg_log_r [DEPTH];
  logic [AW-1:0]        ila_log_r [DEPTH];
  logic [3:0]           vlg_cnt_r;
  logic [3:0]           ila_cnt_r;
  logic                 overflow_r;

  logic                 vlg_ren_real_s;
  logic                 ila_ren_real_s;
  logic [DEPTH-1:0]     vlg_match_s;
  logic [DEPTH-1:0]     ila_match_s;
  logic [DW-1:0]        vlg_hit_data_s;
  logic [DW-1:0]        ila_hit_data_s;
  logic                 vlg_miss_s;
  logic                 ila_miss_s;
  logic                 same_miss_s;
  logic                 ila_new_s;
  logic [DEPTH-1:0]     free_s;
  logic [DEPTH-1:0]     free1_s;
  logic [DEPTH-1:0]     rest_s;
  logic [DEPTH-1:0]     free2_s;
  logic [DEPTH-1:0]     vlg_alloc_s;
  logic [DEPTH-1:0]     ila_alloc_s;
  logic                 ovf_set_s;
  logic                 log_match_s;

  assign vlg_ren_real_s = vlg_ren & ~compare & start_r;
  assign ila_ren_real_s = ila_ren & ~compare & start_r;

  // Table lookup; the descending scan leaves the lowest matching index in front.
  always_comb begin
    vlg_match_s    = '0;
    ila_match_s    = '0;
    vlg_hit_data_s = '0;
    ila_hit_data_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      vlg_match_s[i] = v_r[i] & (addr_r[i] == vlg_raddr);
      ila_match_s[i] = v_r[i] & (addr_r[i] == ila_raddr);
      vlg_hit_data_s = vlg_match_s[i] ? data_r[i] : vlg_hit_data_s;
      ila_hit_data_s = ila_match_s[i] ? data_r[i] : ila_hit_data_s;
    end
  end

  assign vlg_miss_s  = vlg_ren_real_s & ~(|vlg_match_s);
  assign ila_miss_s  = ila_ren_real_s & ~(|ila_match_s);
  assign same_miss_s = vlg_miss_s & ila_miss_s & (vlg_raddr == ila_raddr);
  assign ila_new_s   = ila_miss_s & ~same_miss_s;

  // Read data: hits replay the table, a shared-address double miss sees the vlg value.
  always_comb begin
    vlg_rdata = vlg_r_rand_input;
    ila_rdata = ila_r_rand_input;
    if (vlg_ren_real_s && (|vlg_match_s)) begin
      vlg_rdata = vlg_hit_data_s;
    end else begin
      vlg_rdata = vlg_r_rand_input;
    end
    if (ila_ren_real_s && (|ila_match_s)) begin
      ila_rdata = ila_hit_data_s;
    end else if (same_miss_s) begin
      ila_rdata = vlg_r_rand_input;
    end else begin
      ila_rdata = ila_r_rand_input;
    end
  end

  // Lowest and second-lowest free entries as one-hot masks (x & -x isolates the low bit).
  always_comb begin
    free_s      = ~v_r;
    free1_s     = free_s & (~free_s + ONE_C);
    rest_s      = free_s & ~free1_s;
    free2_s     = rest_s & (~rest_s + ONE_C);
    vlg_alloc_s = vlg_miss_s ? free1_s : '0;
    ila_alloc_s = ila_new_s ? (vlg_miss_s ? free2_s : free1_s) : '0;
    ovf_set_s   = (vlg_miss_s & ~(|free1_s)) |
                  (ila_new_s & ~(|(vlg_miss_s ? free2_s : free1_s)));
  end

  // Verdict: both sides read the same number of times in the same address order.
  always_comb begin
    log_match_s = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      log_match_s = log_match_s &
                    ((4'(i) >= vlg_cnt_r) | (vlg_log_r[i] == ila_log_r[i]));
    end
    equal = compare & ~overflow_r & (vlg_cnt_r == ila_cnt_r) & log_match_s;
  end

  assign overflow = overflow_r;

  // State update; reset wins over issue and any allocation in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_r    <= 1'b0;
      v_r        <= '0;
      vlg_cnt_r  <= 4'd0;
      ila_cnt_r  <= 4'd0;
      overflow_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i]    <= '0;
        data_r[i]    <= '0;
        vlg_log_r[i] <= '0;
        ila_log_r[i] <= '0;
      end
    end else begin
      if (issue) begin
        start_r <= 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (vlg_alloc_s[i]) begin
          v_r[i]    <= 1'b1;
          addr_r[i] <= vlg_raddr;
          data_r[i] <= vlg_r_rand_input;
        end else if (ila_alloc_s[i]) begin
          v_r[i]    <= 1'b1;
          addr_r[i] <= ila_raddr;
          data_r[i] <= ila_r_rand_input;
        end
        if (vlg_ren_real_s && (vlg_cnt_r == 4'(i))) begin
          vlg_log_r[i] <= vlg_raddr;
        end
        if (ila_ren_real_s && (ila_cnt_r == 4'(i))) begin
          ila_log_r[i] <= ila_raddr;
        end
      end
      overflow_r <= overflow_r | ovf_set_s;
      if (vlg_ren_real_s && (vlg_cnt_r != CNT_MAX_C)) begin
        vlg_cnt_r <= vlg_cnt_r + 4'd1;
      end
      if (ila_ren_real_s && (ila_cnt_r != CNT_MAX_C)) begin
        ila_cnt_r <= ila_cnt_r + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_absmem_rd.sv
// Bench for absmem_rd: directed scenarios plus random traffic, all checked
// each cycle against a queue-based model of the read-record semantics.
module tb_absmem_rd;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          issue;
  logic          compare;
  logic [AW-1:0] vlg_raddr;
  logic          vlg_ren;
  logic [DW-1:0] vlg_r_rand_input;
  logic [DW-1:0] vlg_rdata;
  logic [AW-1:0] ila_raddr;
  logic          ila_ren;
  logic [DW-1:0] ila_r_rand_input;
  logic [DW-1:0] ila_rdata;
  logic          equal;
  logic          overflow;

  int total;
  int bad;

  absmem_rd #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .issue            (issue),
    .compare          (compare),
    .vlg_raddr        (vlg_raddr),
    .vlg_ren          (vlg_ren),
    .vlg_r_rand_input (vlg_r_rand_input),
    .vlg_rdata        (vlg_rdata),
    .ila_raddr        (ila_raddr),
    .ila_ren          (ila_ren),
    .ila_r_rand_input (ila_r_rand_input),
    .ila_rdata        (ila_rdata),
    .equal            (equal),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: records kept in allocation order (= lowest free index order).
  bit            m_start;
  logic [AW-1:0] m_addr[$];
  logic [DW-1:0] m_data[$];
  bit            m_ovf;
  int            m_vc;
  int            m_ic;
  logic [AW-1:0] m_vlog[$];
  logic [AW-1:0] m_ilog[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_rec(input logic [AW-1:0] a);
    for (int i = 0; i < m_addr.size(); i++) begin
      if (m_addr[i] == a) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_start = 1'b0;
    m_addr.delete();
    m_data.delete();
    m_ovf = 1'b0;
    m_vc = 0;
    m_ic = 0;
    m_vlog.delete();
    m_ilog.delete();
  endtask

  // Apply inputs for one cycle; outputs become observable 4 time units later.
  task automatic drive(input bit r, input bit iss, input bit cmp,
                       input bit ven, input logic [AW-1:0] va, input logic [DW-1:0] vr,
                       input bit ien, input logic [AW-1:0] ia, input logic [DW-1:0] ir);
    rst = r; issue = iss; compare = cmp;
    vlg_ren = ven; vlg_raddr = va; vlg_r_rand_input = vr;
    ila_ren = ien; ila_raddr = ia; ila_r_rand_input = ir;
    #4;
  endtask

  // Compare outputs with the model, advance the model, then cross the clock edge.
  task automatic tick();
    bit vq, iq, vmiss, imiss, same, eq;
    int vi, ii;
    logic [DW-1:0] ev, ei;
    vq = vlg_ren && !compare && m_start;
    iq = ila_ren && !compare && m_start;
    vi = find_rec(vlg_raddr);
    ii = find_rec(ila_raddr);
    vmiss = vq && (vi < 0);
    imiss = iq && (ii < 0);
    same  = vmiss && imiss && (vlg_raddr == ila_raddr);
    ev = (vq && vi >= 0) ? m_data[vi] : vlg_r_rand_input;
    ei = (iq && ii >= 0) ? m_data[ii] : (same ? vlg_r_rand_input : ila_r_rand_input);
    eq = compare && !m_ovf && (m_vc == m_ic) && (m_vlog.size() == m_ilog.size());
    for (int k = 0; k < m_vlog.size() && k < m_ilog.size(); k++) begin
      if (m_vlog[k] != m_ilog[k]) eq = 1'b0;
    end
    chk("vlg_rdata", 32'(vlg_rdata), 32'(ev));
    chk("ila_rdata", 32'(ila_rdata), 32'(ei));
    chk("equal", 32'(equal), 32'(eq));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (!rst) begin
      model_clear();
    end else begin
      if (vmiss) begin
        if (m_addr.size() < DEPTH) begin
          m_addr.push_back(vlg_raddr); m_data.push_back(vlg_r_rand_input);
        end else m_ovf = 1'b1;
      end
      if (imiss && !same) begin
        if (m_addr.size() < DEPTH) begin
          m_addr.push_back(ila_raddr); m_data.push_back(ila_r_rand_input);
        end else m_ovf = 1'b1;
      end
      if (vq) begin
        if (m_vlog.size() < DEPTH) m_vlog.push_back(vlg_raddr);
        if (m_vc < 15) m_vc++;
      end
      if (iq) begin
        if (m_ilog.size() < DEPTH) m_ilog.push_back(ila_raddr);
        if (m_ic < 15) m_ic++;
      end
      if (issue) m_start = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r, input bit iss, input bit cmp);
    drive(r, iss, cmp, 1'b0, 8'h00, 8'h5A, 1'b0, 8'h00, 8'hC3);
    tick();
  endtask

  task automatic rearm();
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    @(posedge clk);
    #1;
    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h4E, 1'b1, 8'h10, 8'hB2);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h4E, 1'b1, 8'h10, 8'hB2);
    chk("rst_vlg", 32'(vlg_rdata), 32'h4E);
    chk("rst_ila", 32'(ila_rdata), 32'hB2);
    chk("rst_eq", 32'(equal), 32'h0);
    tick();

    // First read records, later read from the other side replays it
    idle(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 8'h00);
    chk("r034_vlg", 32'(vlg_rdata), 32'hA5);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h3C);
    chk("r034_ila", 32'(ila_rdata), 32'hA5);
    tick();

    // Reset discards the record
    rearm();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 8'h77, 1'b0, 8'h00, 8'h00);
    chk("r038", 32'(vlg_rdata), 32'h77);
    tick();

    // Simultaneous miss on one address, then three more fill the table exactly
    rearm();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 8'h11, 1'b1, 8'h22, 8'h99);
    chk("r035_vlg", 32'(vlg_rdata), 32'h11);
    chk("r035_ila", 32'(ila_rdata), 32'h11);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h30 + k), 8'(8'h40 + k), 1'b0, 8'h00, 8'h00);
      tick();
    end
    idle(1'b1, 1'b0, 1'b0);
    chk("r035_noovf", 32'(overflow), 32'h0);

    // Overflow with five distinct vlg addresses
    rearm();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h50 + k), 8'(8'h60 + k), 1'b0, 8'h00, 8'h00);
      tick();
    end
    chk("r036_ovf", 32'(overflow), 32'h1);
    idle(1'b1, 1'b0, 1'b1);

    // One free entry, two different misses: ila loses
    rearm();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h70 + k), 8'(8'h80 + k), 1'b0, 8'h00, 8'h00);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h7A, 8'hE1, 1'b1, 8'h7B, 8'hE2);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h7A, 8'h00, 1'b1, 8'h7B, 8'hD4);
    chk("r026_vhit", 32'(vlg_rdata), 32'hE1);
    chk("r026_imiss", 32'(ila_rdata), 32'hD4);
    tick();

    // Address-order verdict
    for (int t = 0; t < 2; t++) begin
      rearm();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h21, 1'b1, 8'h01, 8'h31);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h22, 1'b1, (t == 0) ? 8'h03 : 8'h02, 8'h32);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 8'h9F, 1'b0, 8'h00, 8'h00);
      chk("r037_eq", 32'(equal), (t == 0) ? 32'h0 : 32'h1);
      chk("r039_vlg", 32'(vlg_rdata), 32'h9F);
      tick();
      idle(1'b1, 1'b0, 1'b1);
    end

    // Random traffic
    rearm();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 7)), 8'($urandom),
            ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 7)), 8'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
